// File: rtl/router_np.sv
// N-port single-flit router: per-input FIFO, per-output round-robin arbiter, registered output.
// 2-cycle input-to-output latency; outputs hold under !out_ready, in_ready drops when the FIFO is full.
module router_np #(
  parameter int NUM_PORTS        = 4,
  parameter int DATA_PACKET_SIZE = 32,
  parameter int DEST_W           = 8,
  parameter int RANK_BEGIN       = 5,
  parameter int RANK_END         = 6,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                 clk_rtr,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 in_valid,
  input  logic [NUM_PORTS*DATA_PACKET_SIZE-1:0] in_data,
  output logic [NUM_PORTS-1:0]                 in_ready,
  output logic [NUM_PORTS-1:0]                 out_valid,
  output logic [NUM_PORTS*DATA_PACKET_SIZE-1:0] out_data,
  input  logic [NUM_PORTS-1:0]                 out_ready,
  output logic [15:0]                          drop_cnt
);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int DW     = DATA_PACKET_SIZE;

  if (NUM_PORTS < 3) begin : g_chk_ports
    $error("router_np: NUM_PORTS must be >= 3");
  end
  if (RANK_END - RANK_BEGIN + 1 != NUM_PORTS - 2) begin : g_chk_rank
    $error("router_np: rank range must cover exactly NUM_PORTS-2 local ports");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("router_np: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [DW-1:0]        r_mem      [NUM_PORTS][FIFO_DEPTH];
  logic [PW:0]          r_wptr     [NUM_PORTS];
  logic [PW:0]          r_wptr_vis [NUM_PORTS];
  logic [PW:0]          r_rptr     [NUM_PORTS];
  logic [PORT_W-1:0]    r_arb_ptr  [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_out_vld;
  logic [DW-1:0]        r_out_dat  [NUM_PORTS];
  logic [15:0]          r_drop_cnt;

  logic [NUM_PORTS-1:0] w_push, w_pop, w_empty, w_drop, w_gnt_vld, w_can_load;
  logic [DW-1:0]        w_head    [NUM_PORTS];
  logic [PORT_W-1:0]    w_route   [NUM_PORTS];
  logic [PORT_W-1:0]    w_gnt_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_req     [NUM_PORTS];
  logic [16:0]          w_drop_sum;

  // Writes become visible to routing one cycle after they land (r_wptr_vis),
  // which fixes the input-to-output latency at two cycles without adding storage.
  always_comb begin
    int d;
    d = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = ((r_wptr[i] - r_rptr[i]) != (PW+1)'(FIFO_DEPTH));
      w_empty[i]  = (r_wptr_vis[i] == r_rptr[i]);
      w_push[i]   = in_valid[i] && in_ready[i];
      w_head[i]   = r_mem[i][r_rptr[i][PW-1:0]];
      d = int'(w_head[i][DW-1 -: DEST_W]);
      if (d < RANK_BEGIN)     w_route[i] = PORT_W'(0);
      else if (d > RANK_END)  w_route[i] = PORT_W'(1);
      else                    w_route[i] = PORT_W'(2 + d - RANK_BEGIN);
      w_drop[i] = !w_empty[i] && (w_route[i] == PORT_W'(i));
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_can_load[o] = !r_out_vld[o] || out_ready[o];
      w_req[o]      = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        w_req[o][i] = !w_empty[i] && (w_route[i] == PORT_W'(o)) && (o != i);
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = '0;
      // Scan downwards so the candidate closest to the pointer is assigned last and wins.
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        idx = (int'(r_arb_ptr[o]) + k) % NUM_PORTS;
        if (w_can_load[o] && w_req[o][idx]) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_idx[o] = PORT_W'(idx);
        end
      end
    end
  end

  always_comb begin
    w_pop      = w_drop;
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int o = 0; o < NUM_PORTS; o++)
      if (w_gnt_vld[o]) w_pop[w_gnt_idx[o]] = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++)
      if (w_drop[i]) w_drop_sum = w_drop_sum + 17'd1;
  end

  always_ff @(posedge clk_rtr) begin
    for (int i = 0; i < NUM_PORTS; i++)
      if (w_push[i]) r_mem[i][r_wptr[i][PW-1:0]] <= in_data[i*DW +: DW];
  end

  always_ff @(posedge clk_rtr) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_wptr[i]     <= '0;
        r_wptr_vis[i] <= '0;
        r_rptr[i]     <= '0;
        r_arb_ptr[i]  <= '0;
        r_out_dat[i]  <= '0;
      end
      r_out_vld  <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        r_wptr_vis[i] <= r_wptr[i];
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt_vld[o]) begin
          r_out_vld[o] <= 1'b1;
          r_out_dat[o] <= w_head[w_gnt_idx[o]];
          r_arb_ptr[o] <= (w_gnt_idx[o] == PORT_W'(NUM_PORTS - 1)) ? '0 : w_gnt_idx[o] + 1'b1;
        end else if (out_ready[o]) begin
          r_out_vld[o] <= 1'b0;
        end
      end
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    assign out_data[o*DW +: DW] = r_out_dat[o];
  end
  assign out_valid = r_out_vld;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_router_np.sv
// Scoreboard bench for router_np: expected packets queued per output at stimulus time, popped on output transfers.
module tb_router_np;
  localparam int NP = 4;
  localparam int DW = 32;

  logic clk_rtr = 1'b0;
  always #5 clk_rtr = ~clk_rtr;

  logic             reset;
  logic [NP-1:0]    in_valid, in_ready, out_valid, out_ready;
  logic [NP*DW-1:0] in_data, out_data;
  logic [15:0]      drop_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q [NP][$];

  router_np #(
    .NUM_PORTS(NP), .DATA_PACKET_SIZE(DW), .DEST_W(8),
    .RANK_BEGIN(5), .RANK_END(6), .FIFO_DEPTH(4)
  ) dut (
    .clk_rtr(clk_rtr), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  task automatic cyc();
    @(posedge clk_rtr);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int dest, input int src, input int seq);
    return {8'(dest), 8'(src), 16'(seq)};
  endfunction

  function automatic int route_of(input int dest);
    if (dest < 5) return 0;
    if (dest > 6) return 1;
    return 2 + dest - 5;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; in_data = '0; out_ready = '1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    for (int p = 0; p < NP; p++) exp_q[p].delete();
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    reset = 1'b1; in_valid = '1; out_ready = '1;
    for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = mk(5, p, 0);
    cyc(); cyc();
    vectors++;
    if (out_valid !== '0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0000", out_valid); end
    vectors++;
    if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
    vectors++;
    if (in_ready !== '1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1111", in_ready); end
    reset = 1'b0; in_valid = '0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      vectors++;
      if (out_valid !== '0 || drop_cnt !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_no_writes c%0d: got valid %b drop %0d, required 0000 / 0", c, out_valid, drop_cnt);
      end
    end
    d = out_data[2*DW +: DW];
    vectors++;
    if (d !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h, required 0", d); end
  endtask

  task automatic test_single();
    logic [NP-1:0] ev;
    do_reset();
    in_data[0 +: DW] = 32'h050000AA; in_valid[0] = 1'b1;
    vectors++;
    if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL single_in_ready: got %b, required 1", in_ready[0]); end
    cyc();
    in_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      ev = (k == 3) ? 4'b0100 : 4'b0000;
      vectors++;
      if (out_valid !== ev) begin miscompares++; $display("FAIL single_valid edge+%0d: got %b, required %b", k, out_valid, ev); end
      if (k == 3) begin
        vectors++;
        if (out_data[2*DW +: DW] !== 32'h050000AA) begin
          miscompares++; $display("FAIL single_data: got %h, required 050000aa", out_data[2*DW +: DW]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_round_robin();
    int seq [NP];
    int order [3];
    logic [NP-1:0] acc;
    logic [DW-1:0] e;
    order[0] = 0; order[1] = 1; order[2] = 3;
    do_reset();
    for (int p = 0; p < NP; p++) seq[p] = 0;
    for (int j = 0; j < 12; j++) exp_q[2].push_back(mk(5, order[j % 3], j / 3));
    for (int c = 0; c < 40; c++) begin
      for (int s = 0; s < NP; s++) begin
        in_valid[s] = (s != 2) && (seq[s] < 4);
        in_data[s*DW +: DW] = mk(5, s, seq[s]);
      end
      acc = in_valid & in_ready;
      for (int p = 0; p < NP; p++) if (out_valid[p] && out_ready[p]) begin
        vectors++;
        if (exp_q[p].size() == 0) begin
          miscompares++; $display("FAIL rr_unexpected port %0d: got %h, required none", p, out_data[p*DW +: DW]);
        end else begin
          e = exp_q[p].pop_front();
          if (out_data[p*DW +: DW] !== e) begin
            miscompares++; $display("FAIL rr_order port %0d: got %h, required %h", p, out_data[p*DW +: DW], e);
          end
        end
      end
      if (exp_q[2].size() == 0 && seq[0] == 4 && seq[1] == 4 && seq[3] == 4) break;
      cyc();
      for (int s = 0; s < NP; s++) if (acc[s]) seq[s]++;
    end
    in_valid = '0;
    vectors++;
    if (exp_q[2].size() != 0) begin miscompares++; $display("FAIL rr_drain: got %0d left, required 0", exp_q[2].size()); end
  endtask

  task automatic test_routes();
    int dests [5];
    int n;
    logic [DW-1:0] e;
    dests[0] = 4; dests[1] = 6; dests[2] = 7; dests[3] = 0; dests[4] = 255;
    do_reset();
    n = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid[2] = (n < 5);
      if (n < 5) in_data[2*DW +: DW] = mk(dests[n], 2, n);
      for (int p = 0; p < NP; p++) if (out_valid[p] && out_ready[p]) begin
        vectors++;
        if (exp_q[p].size() == 0) begin
          miscompares++; $display("FAIL route_unexpected port %0d: got %h, required none", p, out_data[p*DW +: DW]);
        end else begin
          e = exp_q[p].pop_front();
          if (out_data[p*DW +: DW] !== e) begin
            miscompares++; $display("FAIL route_data port %0d: got %h, required %h", p, out_data[p*DW +: DW], e);
          end
        end
      end
      if (in_valid[2] && in_ready[2]) begin
        exp_q[route_of(dests[n])].push_back(mk(dests[n], 2, n));
        n++;
      end
      cyc();
    end
    in_valid = '0;
    for (int p = 0; p < NP; p++) begin
      vectors++;
      if (exp_q[p].size() != 0) begin miscompares++; $display("FAIL route_drain port %0d: got %0d left, required 0", p, exp_q[p].size()); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [DW-1:0] e;
    do_reset();
    out_ready[1] = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid[2] = 1'b1;
      in_data[2*DW +: DW] = mk(9, 2, n);
      if (out_valid[1] && exp_q[1].size() != 0) begin
        vectors++;
        if (out_data[1*DW +: DW] !== exp_q[1][0]) begin
          miscompares++; $display("FAIL bp_hold: got %h, required %h", out_data[1*DW +: DW], exp_q[1][0]);
        end
      end
      if (in_ready[2]) begin exp_q[1].push_back(mk(9, 2, n)); n++; end
      cyc();
    end
    vectors++;
    if (n != 5) begin miscompares++; $display("FAIL bp_accepts: got %0d, required 5", n); end
    vectors++;
    if (in_ready[2] !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_low: got %b, required 0", in_ready[2]); end
    vectors++;
    if (out_valid !== 4'b0010) begin miscompares++; $display("FAIL bp_out_valid: got %b, required 0010", out_valid); end
    in_valid = '0; out_ready[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int p = 0; p < NP; p++) if (out_valid[p] && out_ready[p]) begin
        vectors++;
        if (exp_q[p].size() == 0) begin
          miscompares++; $display("FAIL bp_unexpected port %0d: got %h, required none", p, out_data[p*DW +: DW]);
        end else begin
          e = exp_q[p].pop_front();
          if (out_data[p*DW +: DW] !== e) begin
            miscompares++; $display("FAIL bp_order port %0d: got %h, required %h", p, out_data[p*DW +: DW], e);
          end
        end
      end
      cyc();
      if (c == 0) begin
        vectors++;
        if (in_ready[2] !== 1'b1) begin miscompares++; $display("FAIL bp_in_ready_rise: got %b, required 1", in_ready[2]); end
      end
    end
    vectors++;
    if (exp_q[1].size() != 0) begin miscompares++; $display("FAIL bp_drain: got %0d left, required 0", exp_q[1].size()); end
  endtask

  task automatic test_uturn();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      in_valid[0] = 1'b1; in_data[0 +: DW] = mk(2, 0, c);
      cyc();
    end
    in_valid = '0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (out_valid !== '0) begin miscompares++; $display("FAIL uturn_valid c%0d: got %b, required 0000", c, out_valid); end
      cyc();
    end
    vectors++;
    if (drop_cnt !== 16'd3) begin miscompares++; $display("FAIL uturn_cnt3: got %0d, required 3", drop_cnt); end
    in_valid[3] = 1'b1; in_data[3*DW +: DW] = mk(6, 3, 0);
    in_valid[1] = 1'b1; in_data[1*DW +: DW] = mk(200, 1, 0);
    cyc();
    in_valid = '0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (out_valid !== '0) begin miscompares++; $display("FAIL uturn2_valid c%0d: got %b, required 0000", c, out_valid); end
      cyc();
    end
    vectors++;
    if (drop_cnt !== 16'd5) begin miscompares++; $display("FAIL uturn_cnt5: got %0d, required 5", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid[2] = 1'b1; in_data[2*DW +: DW] = mk(9, 2, c);
      cyc();
    end
    in_valid = '0;
    vectors++;
    if (out_valid !== 4'b0010) begin miscompares++; $display("FAIL mid_setup: got %b, required 0010", out_valid); end
    reset = 1'b1;
    cyc();
    vectors++;
    if (out_valid !== '0) begin miscompares++; $display("FAIL mid_reset_valid: got %b, required 0000", out_valid); end
    vectors++;
    if (in_ready !== '1) begin miscompares++; $display("FAIL mid_reset_ready: got %b, required 1111", in_ready); end
    reset = 1'b0; out_ready = '1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      vectors++;
      if (out_valid !== '0) begin miscompares++; $display("FAIL mid_stale c%0d: got %b, required 0000", c, out_valid); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; out_ready = '1;
    test_reset();
    test_single();
    test_round_robin();
    test_routes();
    test_backpressure();
    test_uturn();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
